// File: rtl/cnn_pkg.sv
// Shared types and helpers for the CNN inference controller and its result cache.
package cnn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    LAUNCH,
    WAIT,
    READ,
    COMMIT
  } state_t;

  function automatic int cls_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cnn_result_cache.sv
// Per-image result cache: valid vector plus class array, one async read port, one write port.
// Clear is a single-cycle wipe of the valid bits; clear takes priority over a same-cycle write.
module cnn_result_cache #(
  parameter int IDX_W = 5,
  parameter int CLS_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [IDX_W-1:0] rd_index,
  output logic             rd_valid,
  output logic [CLS_W-1:0] rd_class,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [CLS_W-1:0] wr_class
);

  localparam int DEPTH = 2 ** IDX_W;

  logic [DEPTH-1:0] valid;
  logic [CLS_W-1:0] cls_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      cls_mem[wr_index] <= wr_class;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_class = cls_mem[rd_index];

endmodule

// File: rtl/cnn_inference_controller.sv
// Sequences one CNN inference: cache lookup, engine launch/wait, score readout with argmax, commit.
// Miss latency 3 + wait cycles + NUM_CLASSES + 1; hit latency 2; start ignored while busy.
module cnn_inference_controller
  import cnn_pkg::*;
#(
  parameter int          NUM_CLASSES    = 10,
  parameter int          SCORE_W        = 32,
  parameter int          IDX_W          = 5,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  localparam int         CLS_W          = cls_width(NUM_CLASSES)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [IDX_W-1:0]          image_index,
  input  logic                      use_cache,
  input  logic                      cache_clear,
  output logic                      eng_start,
  input  logic                      eng_done,
  output logic [CLS_W-1:0]          eng_rd_addr,
  input  logic signed [SCORE_W-1:0] eng_rd_data,
  output logic                      busy,
  output logic                      done,
  output logic [CLS_W-1:0]          predicted_class,
  output logic signed [SCORE_W-1:0] max_score,
  output logic                      cache_hit,
  output logic                      timeout_err
);

  localparam logic [CLS_W:0] RD_LAST = (CLS_W+1)'(NUM_CLASSES);
  localparam logic [CLS_W:0] RD_PEN  = (CLS_W+1)'(NUM_CLASSES - 1);

  state_t                    state;
  logic [IDX_W-1:0]          idx_r;
  logic                      use_cache_r;
  logic                      hit_r;
  logic                      to_r;
  logic [31:0]               wait_cnt;
  logic [CLS_W:0]            rd_cnt;
  logic signed [SCORE_W-1:0] best_score;
  logic [CLS_W-1:0]          best_idx;

  logic                      c_rd_valid;
  logic [CLS_W-1:0]          c_rd_class;
  logic                      c_clear;
  logic                      c_wr_en;

  assign c_clear = (state == IDLE) && cache_clear;
  assign c_wr_en = (state == COMMIT) && !hit_r && !to_r;

  cnn_result_cache #(
    .IDX_W (IDX_W),
    .CLS_W (CLS_W)
  ) u_cache (
    .clk      (clk),
    .reset    (reset),
    .clear    (c_clear),
    .rd_index (idx_r),
    .rd_valid (c_rd_valid),
    .rd_class (c_rd_class),
    .wr_en    (c_wr_en),
    .wr_index (idx_r),
    .wr_class (best_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      idx_r           <= '0;
      use_cache_r     <= 1'b0;
      hit_r           <= 1'b0;
      to_r            <= 1'b0;
      wait_cnt        <= '0;
      rd_cnt          <= '0;
      best_score      <= '0;
      best_idx        <= '0;
      eng_start       <= 1'b0;
      eng_rd_addr     <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      predicted_class <= '0;
      max_score       <= '0;
      cache_hit       <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      eng_start <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            idx_r       <= image_index;
            use_cache_r <= use_cache;
            busy        <= 1'b1;
            state       <= LOOKUP;
          end
        end
        LOOKUP: begin
          to_r       <= 1'b0;
          best_score <= '0;
          best_idx   <= '0;
          if (use_cache_r && c_rd_valid) begin
            hit_r <= 1'b1;
            state <= COMMIT;
          end else begin
            hit_r     <= 1'b0;
            eng_start <= 1'b1;
            state     <= LAUNCH;
          end
        end
        LAUNCH: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (eng_done) begin
            rd_cnt      <= '0;
            eng_rd_addr <= '0;
            state       <= READ;
          end else if (TIMEOUT_CYCLES != 0 && wait_cnt == TIMEOUT_CYCLES - 1) begin
            to_r  <= 1'b1;
            state <= COMMIT;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        READ: begin
          // Data seen in cycle k belongs to the address issued in cycle k-1.
          if (rd_cnt != '0 && eng_rd_data > best_score) begin
            best_score <= eng_rd_data;
            best_idx   <= CLS_W'(rd_cnt - (CLS_W+1)'(1));
          end
          if (rd_cnt < RD_PEN) begin
            eng_rd_addr <= eng_rd_addr + CLS_W'(1);
          end
          if (rd_cnt == RD_LAST) begin
            eng_rd_addr <= '0;
            state       <= COMMIT;
          end else begin
            rd_cnt <= rd_cnt + (CLS_W+1)'(1);
          end
        end
        COMMIT: begin
          done            <= 1'b1;
          busy            <= 1'b0;
          cache_hit       <= hit_r;
          timeout_err     <= to_r;
          predicted_class <= hit_r ? c_rd_class : (to_r ? '0 : best_idx);
          max_score       <= (hit_r || to_r) ? '0 : best_score;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_inference_controller.sv
// Directed bench for cnn_inference_controller with a behavioural dense-engine model.
module tb_cnn_inference_controller;

  localparam int NC    = 10;
  localparam int SW    = 32;
  localparam int IW    = 5;
  localparam int CW    = 4;
  localparam int unsigned TO = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic [IW-1:0]        image_index;
  logic                 use_cache;
  logic                 cache_clear;
  logic                 eng_start;
  logic                 eng_done;
  logic [CW-1:0]        eng_rd_addr;
  logic signed [SW-1:0] eng_rd_data;
  logic                 busy;
  logic                 done;
  logic [CW-1:0]        predicted_class;
  logic signed [SW-1:0] max_score;
  logic                 cache_hit;
  logic                 timeout_err;

  logic signed [SW-1:0] scores [16];
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Results of the most recent run_inference call.
  logic                 r_got;
  int                   r_lat;
  int                   r_starts;
  logic [CW-1:0]        r_cls;
  logic signed [SW-1:0] r_score;
  logic                 r_hit;
  logic                 r_to;

  cnn_inference_controller #(
    .NUM_CLASSES    (NC),
    .SCORE_W        (SW),
    .IDX_W          (IW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .image_index     (image_index),
    .use_cache       (use_cache),
    .cache_clear     (cache_clear),
    .eng_start       (eng_start),
    .eng_done        (eng_done),
    .eng_rd_addr     (eng_rd_addr),
    .eng_rd_data     (eng_rd_data),
    .busy            (busy),
    .done            (done),
    .predicted_class (predicted_class),
    .max_score       (max_score),
    .cache_hit       (cache_hit),
    .timeout_err     (timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    eng_rd_data <= scores[eng_rd_addr];
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // dly > 0: eng_done pulses dly cycles after eng_start; dly <= 0: engine never finishes.
  task automatic run_inference(input logic [IW-1:0] idx, input logic uc, input logic clr, input int dly);
    int t0;
    int la;
    logic launched;
    r_got = 1'b0; r_lat = -1; r_starts = 0;
    launched = 1'b0; la = 0;
    @(negedge clk);
    start = 1'b1; image_index = idx; use_cache = uc; cache_clear = clr;
    @(negedge clk);
    start = 1'b0; cache_clear = 1'b0;
    t0 = cyc;
    for (int i = 0; i < 200; i++) begin
      if (done) begin
        r_got = 1'b1; r_lat = cyc - t0;
        r_cls = predicted_class; r_score = max_score;
        r_hit = cache_hit; r_to = timeout_err;
        break;
      end
      if (eng_start) begin
        r_starts++; launched = 1'b1; la = i;
      end
      eng_done = (dly > 0) && launched && (i == la + dly);
      @(negedge clk);
    end
    eng_done = 1'b0;
  endtask

  initial begin
    int seen_done;
    reset = 1'b1; start = 1'b0; image_index = '0; use_cache = 1'b0;
    cache_clear = 1'b0; eng_done = 1'b0;
    scores = '{3, -7, 12, 12, 0, -1, 4, 9, 2, 1, 0, 0, 0, 0, 0, 0};
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_eng_start", eng_start, 0);
    chk("rst_class", predicted_class, 0);
    chk("rst_score", max_score, 0);
    chk("rst_flags", {cache_hit, timeout_err}, 0);
    reset = 1'b0;

    // Miss path with a mid-list tie at the maximum.
    run_inference(5'd3, 1'b1, 1'b0, 5);
    chk("miss_got", r_got, 1);
    chk("miss_lat", r_lat, 19);
    chk("miss_class", r_cls, 2);
    chk("miss_score", r_score, 12);
    chk("miss_hit", r_hit, 0);
    chk("miss_to", r_to, 0);
    chk("miss_starts", r_starts, 1);
    repeat (3) @(negedge clk);
    chk("hold_class", predicted_class, 2);

    // Same index again, served from cache.
    run_inference(5'd3, 1'b1, 1'b0, 5);
    chk("hit_lat", r_lat, 2);
    chk("hit_class", r_cls, 2);
    chk("hit_flag", r_hit, 1);
    chk("hit_score", r_score, 0);
    chk("hit_starts", r_starts, 0);

    // All negative: zero seed wins.
    scores = '{-5, -6, -7, -8, -9, -10, -11, -12, -13, -14, 0, 0, 0, 0, 0, 0};
    run_inference(5'd7, 1'b1, 1'b0, 3);
    chk("neg_class", r_cls, 0);
    chk("neg_score", r_score, 0);
    chk("neg_lat", r_lat, 17);

    // Engine never finishes: timeout.
    run_inference(5'd9, 1'b0, 1'b0, 0);
    chk("to_got", r_got, 1);
    chk("to_lat", r_lat, 19);
    chk("to_flag", r_to, 1);
    chk("to_class", r_cls, 0);
    chk("to_score", r_score, 0);
    chk("to_hit", r_hit, 0);

    scores = '{3, -7, 12, 12, 0, -1, 4, 9, 2, 1, 0, 0, 0, 0, 0, 0};
    run_inference(5'd9, 1'b1, 1'b0, 5);
    chk("after_to_hit", r_hit, 0);
    chk("after_to_starts", r_starts, 1);
    chk("after_to_flag", r_to, 0);

    // Clear together with start on a cached index forces the engine path.
    scores = '{0, 5, -3, 7, 7, 7, 1, 0, 2, 6, 0, 0, 0, 0, 0, 0};
    run_inference(5'd3, 1'b1, 1'b1, 2);
    chk("clr_hit", r_hit, 0);
    chk("clr_starts", r_starts, 1);
    chk("clr_class", r_cls, 3);
    chk("clr_score", r_score, 7);

    // use_cache=0 on a cached index still runs the engine.
    run_inference(5'd3, 1'b0, 1'b0, 2);
    chk("nouse_hit", r_hit, 0);
    chk("nouse_starts", r_starts, 1);

    // Reset in the middle of READ.
    @(negedge clk);
    start = 1'b1; image_index = 5'd12; use_cache = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && !eng_start; i++) @(negedge clk);
    chk("rr_launch", eng_start, 1);
    repeat (2) @(negedge clk);
    eng_done = 1'b1;
    @(negedge clk);
    eng_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rr_busy_read", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rr_busy_after", busy, 0);
    reset = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) seen_done++;
      @(negedge clk);
    end
    chk("rr_no_done", seen_done, 0);
    run_inference(5'd12, 1'b1, 1'b0, 2);
    chk("rr_idx12_hit", r_hit, 0);
    run_inference(5'd3, 1'b1, 1'b0, 2);
    chk("rr_idx3_hit", r_hit, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
